fma_operand_unpack: RTL

- Parametrised, pipelined operand unpack/classify front end for the FMA datapath.
- Accepts one {x, y, z, mode} tuple per cycle over a valid/ready handshake.
- Substitutes identity operands for mul-only and add-only operations, splits fields, and fully classifies each operand.
- Flags special-case outcomes: invalid operation, NaN present, signalling NaN present.
- Generalises the fixed-width fp16 classifier to any IEEE-style format, and adds pipelining, backpressure and flush.

---
 rtl/fma_pkg.sv | 26 ++
 rtl/fma_operand_classify.sv | 38 +++
 rtl/fma_operand_unpack.sv | 105 ++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// fma_pkg: shared constants, operand struct and bias helper for the FMA front end.
// Contents: class-bit indices, default format widths, unpacked-operand struct, one_exp().
package fma_pkg;

    localparam int CLS_ZERO = 0;
    localparam int CLS_SUBN = 1;
    localparam int CLS_INF  = 2;
    localparam int CLS_NAN  = 3;
    localparam int CLS_SNAN = 4;

    localparam int FMA_NE = 5;
    localparam int FMA_NF = 10;

    typedef struct packed {
        logic              sign;
        logic [FMA_NE-1:0] exp;
        logic [FMA_NF:0]   sig;
        logic [4:0]        cls;
    } operand_t;

    // Biased exponent of +1.0 for an ne-bit exponent field.
    function automatic int one_exp(input int ne);
        return (1 << (ne - 1)) - 1;
    endfunction

endpackage

// File: rtl/fma_operand_classify.sv
// fma_operand_classify: combinational field split and class vector for one operand.
// Ports: a (operand in); s (sign), e (exponent, subnormals as 1), m (significand with hidden bit),
//        cls ({snan, nan, inf, subn, zero}).
module fma_operand_classify
    import fma_pkg::*;
#(
    parameter int NE = 5,
    parameter int NF = 10
) (
    input  logic [NE+NF:0] a,
    output logic           s,
    output logic [NE-1:0]  e,
    output logic [NF:0]    m,
    output logic [4:0]     cls
);

    logic [NE-1:0] ef;
    logic [NF-1:0] f;
    logic          ez, emax, fz;

    assign {s, ef, f} = a;
    assign ez   = ef == '0;
    assign emax = &ef;
    assign fz   = f == '0;
    // Subnormals share the minimum normal exponent so downstream alignment needs no special case.
    assign e    = ez ? NE'(!fz) : ef;
    assign m    = {!ez, f};

    always_comb begin
        cls           = '0;
        cls[CLS_ZERO] = ez & fz;
        cls[CLS_SUBN] = ez & !fz;
        cls[CLS_INF]  = emax & fz;
        cls[CLS_NAN]  = emax & !fz;
        cls[CLS_SNAN] = emax & !fz & !f[NF-1];
    end

endmodule

// File: rtl/fma_operand_unpack.sv
// fma_operand_unpack: pipelined operand substitution, unpack and special-case flagging for the FMA.
// Ports: clk/reset (sync, active-high)/flush; in_valid/in_ready with x, y, z, mul, add, negp, negz;
//        out_valid/out_ready with ps, zs, xe/ye/ze, xm/ym/zm, x_cls/y_cls/z_cls, invalid, any_nan, any_snan.
module fma_operand_unpack
    import fma_pkg::*;
#(
    parameter int NE     = 5,
    parameter int NF     = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NE+NF:0]   x,
    input  logic [NE+NF:0]   y,
    input  logic [NE+NF:0]   z,
    input  logic             mul,
    input  logic             add,
    input  logic             negp,
    input  logic             negz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ps,
    output logic             zs,
    output logic [NE-1:0]    xe,
    output logic [NE-1:0]    ye,
    output logic [NE-1:0]    ze,
    output logic [NF:0]      xm,
    output logic [NF:0]      ym,
    output logic [NF:0]      zm,
    output logic [4:0]       x_cls,
    output logic [4:0]       y_cls,
    output logic [4:0]       z_cls,
    output logic             invalid,
    output logic             any_nan,
    output logic             any_snan
);

    localparam int W = 2 + 3*NE + 3*(NF+1) + 15 + 3;
    localparam logic [NE+NF:0] Y_ONE = {1'b0, NE'(one_exp(NE)), NF'(0)};

    logic [NE+NF:0] y_in, z_in;
    logic           xs_c, ys_c, zs_c, p_s, z_s, pinf, nan_in, snan_in, inv_in;
    logic [NE-1:0]  xe_c, ye_c, ze_c;
    logic [NF:0]    xm_c, ym_c, zm_c;
    logic [4:0]     xc, yc, zc;
    logic [W-1:0]   pay;

    logic [STAGES-1:0]        v;
    logic [STAGES-1:0][W-1:0] d;
    logic [STAGES-1:0]        rdy;

    // Identity operands turn the FMA into a plain multiply (z=+0) or add (y=+1.0).
    assign y_in = mul ? y : Y_ONE;
    assign z_in = add ? z : '0;

    fma_operand_classify #(.NE(NE), .NF(NF)) u_x (.a(x),    .s(xs_c), .e(xe_c), .m(xm_c), .cls(xc));
    fma_operand_classify #(.NE(NE), .NF(NF)) u_y (.a(y_in), .s(ys_c), .e(ye_c), .m(ym_c), .cls(yc));
    fma_operand_classify #(.NE(NE), .NF(NF)) u_z (.a(z_in), .s(zs_c), .e(ze_c), .m(zm_c), .cls(zc));

    assign p_s     = xs_c ^ ys_c ^ negp;
    assign z_s     = zs_c ^ negz;
    assign nan_in  = xc[CLS_NAN] | yc[CLS_NAN] | zc[CLS_NAN];
    assign snan_in = xc[CLS_SNAN] | yc[CLS_SNAN] | zc[CLS_SNAN];
    assign pinf    = (xc[CLS_INF] | yc[CLS_INF]) & !xc[CLS_NAN] & !yc[CLS_NAN];
    // inf*0, or inf - inf where product and addend infinities have opposite effective signs.
    assign inv_in  = (xc[CLS_INF] & yc[CLS_ZERO]) | (xc[CLS_ZERO] & yc[CLS_INF])
                   | (pinf & zc[CLS_INF] & (p_s != z_s) & !nan_in) | snan_in;

    assign pay = {p_s, z_s, xe_c, ye_c, ze_c, xm_c, ym_c, zm_c, xc, yc, zc, inv_in, nan_in, snan_in};

    for (genvar g = 0; g < STAGES; g++) begin : g_st
        // Bits below g forced high so the AND covers only stages g..last: stage g can load
        // whenever any stage downstream of it (inclusive) has a bubble or the output drains.
        localparam logic [STAGES-1:0] LOW = STAGES'((1 << g) - 1);
        logic         vin;
        logic [W-1:0] din;
        if (g == 0) begin : g_first
            assign vin = in_valid;
            assign din = pay;
        end else begin : g_next
            assign vin = v[g-1];
            assign din = d[g-1];
        end
        assign rdy[g] = out_ready | ~&(v | LOW);
        always_ff @(posedge clk) begin
            if (reset) begin
                v[g] <= 1'b0;
                d[g] <= '0;
            end else if (flush) begin
                v[g] <= 1'b0;
            end else if (rdy[g]) begin
                v[g] <= vin;
                d[g] <= din;
            end
        end
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = v[STAGES-1];
    assign {ps, zs, xe, ye, ze, xm, ym, zm, x_cls, y_cls, z_cls, invalid, any_nan, any_snan} = d[STAGES-1];

endmodule
